// File: rtl/demux_decode.sv
// demux_decode: registered 1-to-N valid/ready demultiplexer with a one-entry holding register per lane.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   in_valid     input word valid
//   in_ready     input can accept (combinational, independent of in_valid)
//   in_sel       destination lane index; out-of-range words are dropped
//   in_data      input word
//   out_valid    per-lane valid, bit i = lane i
//   out_ready    per-lane ready from the consumer
//   out_data     per-lane held word (unpacked array), qualify with out_valid
//   occupancy    registered count of FULL lanes
//   sel_err      one-cycle pulse after an accepted out-of-range in_sel
// Optional (DEMUX_DECODE_STATS_EN): lane_count per-lane accept counters, drop_count dropped-word counter.
module demux_decode #(
    parameter int DATA_W = 8,
    parameter int NUM_LANES = 8,
    parameter int SEL_W = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SEL_W-1:0]                 in_sel,
    input  logic [DATA_W-1:0]                in_data,
    output logic [NUM_LANES-1:0]             out_valid,
    input  logic [NUM_LANES-1:0]             out_ready,
    output logic [DATA_W-1:0]                out_data [0:NUM_LANES-1],
    output logic [$clog2(NUM_LANES+1)-1:0]   occupancy,
    output logic                             sel_err
`ifdef DEMUX_DECODE_STATS_EN
    ,
    output logic [15:0]                      lane_count [0:NUM_LANES-1],
    output logic [15:0]                      drop_count
`endif
);
    localparam int OCC_W = $clog2(NUM_LANES+1);
    // One extra bit so NUM_LANES itself is representable when it equals 2**SEL_W.
    localparam logic [SEL_W:0] LANES = (SEL_W+1)'(NUM_LANES);
    logic                 sel_ok;
    logic                 drop;
    logic [NUM_LANES-1:0] hit;
    logic [NUM_LANES-1:0] load;
    logic [NUM_LANES-1:0] next_valid;
    logic [OCC_W-1:0]     next_occ;
    always_comb begin
        sel_ok = {1'b0, in_sel} < LANES;
        hit = '0;
        for (int i = 0; i < NUM_LANES; i++) hit[i] = in_sel == SEL_W'(i);
        // A full lane is still ready when it drains this edge, so refill has no bubble.
        in_ready = sel_ok ? |(hit & (~out_valid | out_ready)) : 1'b1;
        load = (in_valid && in_ready) ? hit : '0;
        drop = in_valid && !sel_ok;
        next_valid = (out_valid & ~out_ready) | load;
        next_occ = '0;
        for (int i = 0; i < NUM_LANES; i++) next_occ = next_occ + OCC_W'(next_valid[i]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            occupancy <= '0;
            sel_err <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) out_data[i] <= '0;
        end else begin
            out_valid <= next_valid;
            occupancy <= next_occ;
            sel_err <= drop;
            for (int i = 0; i < NUM_LANES; i++) if (load[i]) out_data[i] <= in_data;
        end
    end
`ifdef DEMUX_DECODE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            for (int i = 0; i < NUM_LANES; i++) lane_count[i] <= '0;
        end else begin
            if (drop) drop_count <= drop_count + 16'd1;
            for (int i = 0; i < NUM_LANES; i++) if (load[i]) lane_count[i] <= lane_count[i] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demux_decode.sv
// tb_demux_decode: self-checking bench for demux_decode using a per-lane reference model.
module tb_demux_decode;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic       a_iv, a_ir, a_err;
    logic [2:0] a_sel;
    logic [7:0] a_d, a_ov, a_or;
    logic [7:0] a_od [0:7];
    logic [3:0] a_occ;
    logic       b_iv, b_ir, b_err;
    logic [2:0] b_sel;
    logic [7:0] b_d;
    logic [4:0] b_ov, b_or;
    logic [7:0] b_od [0:4];
    logic [2:0] b_occ;
`ifdef DEMUX_DECODE_STATS_EN
    logic [15:0] a_lc [0:7];
    logic [15:0] a_dc;
    logic [15:0] b_lc [0:4];
    logic [15:0] b_dc;
`endif
    demux_decode #(.DATA_W(8), .NUM_LANES(8), .SEL_W(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_sel(a_sel), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occupancy(a_occ), .sel_err(a_err)
`ifdef DEMUX_DECODE_STATS_EN
        , .lane_count(a_lc), .drop_count(a_dc)
`endif
    );
    demux_decode #(.DATA_W(8), .NUM_LANES(5), .SEL_W(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_sel(b_sel), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occupancy(b_occ), .sel_err(b_err)
`ifdef DEMUX_DECODE_STATS_EN
        , .lane_count(b_lc), .drop_count(b_dc)
`endif
    );
    int checks = 0;
    int errors = 0;
    bit mv [8];
    logic [7:0] md [8];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic model_ready();
        return !mv[a_sel] || a_or[a_sel];
    endfunction
    task automatic check_a(input string tag);
        logic [7:0] v;
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            v[i] = mv[i];
            n += int'(mv[i]);
        end
        chk({tag, "_ready"}, 32'(a_ir), 32'(model_ready()));
        chk({tag, "_valid"}, 32'(a_ov), 32'(v));
        chk({tag, "_occ"}, 32'(a_occ), n);
        chk({tag, "_err"}, 32'(a_err), 0);
        for (int i = 0; i < 8; i++) if (mv[i]) chk({tag, "_data"}, 32'(a_od[i]), 32'(md[i]));
    endtask
    // Check at the falling edge, advance the model, then move past the rising edge.
    task automatic step_a(input string tag);
        bit acc;
        @(negedge clk);
        check_a(tag);
        acc = a_iv && model_ready();
        for (int i = 0; i < 8; i++) if (mv[i] && a_or[i]) mv[i] = 0;
        if (acc) begin
            mv[a_sel] = 1;
            md[a_sel] = a_d;
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        a_iv = 0; a_sel = 0; a_d = 0; a_or = 0;
        b_iv = 0; b_sel = 0; b_d = 0; b_or = 0;
        for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; end
        rst = 0;
        #1 rst = 1;
        #2;
        chk("rst_valid", 32'(a_ov), 0);
        chk("rst_occ", 32'(a_occ), 0);
        chk("rst_err", 32'(a_err), 0);
        for (int i = 0; i < 8; i++) chk("rst_data", 32'(a_od[i]), 0);
        chk("rst_b_valid", 32'(b_ov), 0);
        @(posedge clk);
        #1 rst = 0;
        for (int s = 0; s < 8; s++) begin
            a_sel = 3'(s);
            #1 chk("idle_ready", 32'(a_ir), 1);
        end
        step_a("idle");
        a_iv = 1; a_sel = 3; a_d = 8'hA5;
        step_a("load3");
        a_d = 8'h77;
        #1;
        chk("busy3_ready", 32'(a_ir), 0);
        chk("load3_valid", 32'(a_ov), 32'h08);
        chk("load3_data", 32'(a_od[3]), 32'hA5);
        chk("load3_occ", 32'(a_occ), 1);
        step_a("busy3");
        a_sel = 5; a_d = 8'hC3;
        step_a("load5");
        a_sel = 3; a_d = 8'h5A; a_or = 8'h08;
        step_a("refill3");
        a_iv = 0; a_or = 0;
        #1;
        chk("refill3_data", 32'(a_od[3]), 32'h5A);
        chk("refill3_valid", 32'(a_ov[3]), 1);
        chk("refill3_occ", 32'(a_occ), 2);
        a_or = 8'hFF;
        step_a("clear");
        a_or = 0;
        a_iv = 1;
        for (int i = 0; i < 8; i++) begin
            a_sel = 3'(i);
            a_d = 8'(i * 8'h11);
            step_a("fill");
        end
        a_iv = 0;
        #1;
        chk("full_occ", 32'(a_occ), 8);
        for (int i = 0; i < 8; i++) chk("full_data", 32'(a_od[i]), 32'(i * 8'h11));
        a_or = 8'hFF;
        step_a("drain_all");
        a_or = 0;
        #1;
        chk("drained_occ", 32'(a_occ), 0);
        chk("drained_valid", 32'(a_ov), 0);
        for (int k = 0; k < 400; k++) begin
            a_iv = 1'($urandom_range(0, 1));
            a_sel = 3'($urandom);
            a_d = 8'($urandom);
            a_or = 8'($urandom);
            step_a("rand");
        end
        a_iv = 0; a_or = 0;
        step_a("rand_end");
        b_iv = 1; b_sel = 2; b_d = 8'h3C;
        @(posedge clk);
        #1 b_iv = 0;
        chk("b_load_valid", 32'(b_ov), 32'h04);
        chk("b_load_data", 32'(b_od[2]), 32'h3C);
        b_iv = 1; b_sel = 6; b_d = 8'hFF;
        #1 chk("b_oor_ready", 32'(b_ir), 1);
        chk("b_pre_err", 32'(b_err), 0);
        @(posedge clk);
        #1 b_iv = 0;
        chk("b_err_pulse", 32'(b_err), 1);
        chk("b_oor_valid", 32'(b_ov), 32'h04);
        chk("b_oor_data", 32'(b_od[2]), 32'h3C);
        chk("b_oor_occ", 32'(b_occ), 1);
`ifdef DEMUX_DECODE_STATS_EN
        chk("b_drop_count", 32'(b_dc), 1);
        chk("b_lane_count", 32'(b_lc[2]), 1);
`endif
        @(posedge clk);
        #1 chk("b_err_clear", 32'(b_err), 0);
        a_or = 8'hFF;
        step_a("pre_rst_clear");
        a_or = 0;
        a_iv = 1;
        for (int i = 0; i < 4; i++) begin
            a_sel = 3'(i);
            a_d = 8'(8'hF0 + i);
            step_a("pre_rst_fill");
        end
        a_iv = 0;
        step_a("pre_rst_hold");
        #2 rst = 1;
        #1;
        chk("async_rst_valid", 32'(a_ov), 0);
        chk("async_rst_occ", 32'(a_occ), 0);
        for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; end
        @(posedge clk);
        #1 rst = 0;
        step_a("post_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
